frame_table_mc: RTL and testbench
=================================

# frame_table_mc

Multi-channel frame descriptor table for the packet scheduler: one flat RAM of N_CH × 2^ADDR_WIDTH entries addressed by {channel, slot}, with a per-entry valid bit, write-to-read bypass, single-entry invalidate and a hardware sweep engine. The sweep zero-fills the whole RAM after reset and clears one channel on request. It replaces per-channel single-port tables and sits between the frame assembler (writer) and the scheduler lookup (reader).

## Interface
- DATA_WIDTH, 40, descriptor width in bits
- ADDR_WIDTH, 4, slot index width per channel (2^ADDR_WIDTH slots)
- N_CH, 4, channel count, power of two ≥ 2; CH_W = clog2(N_CH)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_ch / wr_addr / wr_data  in  CH_W / ADDR_WIDTH / DATA_WIDTH  write target and descriptor
- inv_valid  in  1  clear valid bit of {inv_ch, inv_addr}; ignored while busy
- inv_ch / inv_addr  in  CH_W / ADDR_WIDTH  invalidate target
- rd_valid  in  1  lookup request
- rd_ready  out  1  lookup accepted when rd_valid && rd_ready
- rd_ch / rd_addr  in  CH_W / ADDR_WIDTH  lookup target
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  DATA_WIDTH  descriptor read
- rsp_hit  out  1  valid bit of the entry at accept time, after same-cycle write applies
- flush_req / flush_ch  in  1 / CH_W  request sweep of one channel; accepted only when !busy
- busy  out  1  sweep engine active (INIT or FLUSH)

## Operation
- FSM states: INIT, IDLE, FLUSH.
- INIT is entered on reset. A sweep counter walks all N_CH × 2^ADDR_WIDTH entries, writing zero to the RAM. Valid bits are flops, cleared asynchronously by reset.
- INIT → IDLE after the last entry is written.
- IDLE → FLUSH on an accepted flush_req. In FLUSH, the counter walks 2^ADDR_WIDTH slots of the latched channel, writing zero data and clearing valid bits. FLUSH → IDLE after slot 2^ADDR_WIDTH−1.
- While busy: wr_ready = rd_ready = 0; inv_valid and flush_req are ignored.
- Accepted write: RAM[{ch,addr}] ← data, valid ← 1.
- Same-cycle write and invalidate to the same entry: the write wins, valid = 1.
- Bypass: a lookup accepted in the same cycle as a write to the same entry returns the new data with rsp_hit = 1. A lookup with a same-cycle invalidate to the same entry returns rsp_hit = 0.
- Counter width is CH_W + ADDR_WIDTH. The counter saturates at its end value and never wraps into a second pass.
- rst_n assertion mid-FLUSH or mid-INIT aborts the sweep. After release the block restarts INIT from entry 0.

## Timing
- Reset values: busy = 1, wr_ready = 0, rd_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_hit = 0; state = INIT, counter = 0.
- Lookup latency is 1: accept in cycle T gives rsp_valid, rsp_data and rsp_hit registered at T+1. Back-to-back accepts give back-to-back responses.
- Write-to-read latency: a write at T is visible to a lookup accepted at T, via the bypass.
- INIT lasts exactly N_CH × 2^ADDR_WIDTH cycles after rst_n deasserts; busy falls on the following edge.
- A flush accepted at T sets busy at T+1 and clears it at T+1+2^ADDR_WIDTH.
- A response already in flight when a flush starts is still delivered.

## Configuration
- FRAME_TABLE_PARITY_EN defined: the RAM stores one extra even-parity bit over wr_data. An extra port rsp_perr (out, 1) goes high with rsp_valid when the stored parity mismatches. Sweeps write data zero with parity zero.
- Undefined: no parity bit, no rsp_perr port, RAM width is DATA_WIDTH.

## Structure
- Package frame_table_pkg holds:
  - state enum {INIT, IDLE, FLUSH}
  - clog2 function
  - default parameter constants
  - entry index typedef {ch, slot}
- Sub-module frame_table_sdp: simple dual-port RAM, registered read, same-address write bypass, no reset on the array. Instantiated once, depth N_CH × 2^ADDR_WIDTH. The sweep writes share its write port through a mux, and the sweep has priority.

## Test plan
- Reset release: busy = 1 for 64 cycles (defaults), then 0. Read of ch2 slot 5 → rsp_data = 0, rsp_hit = 0.
- Write ch1 slot 3 = 0x12_3456_789A, read at the next cycle → rsp_hit = 1, same data one cycle after accept.
- Same-cycle write and read of ch0 slot 7 = 0xAB → response in the next cycle carries 0xAB, rsp_hit = 1.
- Fill ch3 slots 0–15, flush ch3 → busy high for 16 cycles, wr_ready = 0 throughout. Reads of ch3 return 0 with hit = 0; ch0 entries are unchanged.
- Same-cycle write and invalidate of ch2 slot 1 → a later read gives hit = 1. Invalidate alone, then read → hit = 0.
- Assert rst_n at the 8th cycle of a flush → after release, a full 64-cycle INIT runs and all reads miss. With FRAME_TABLE_PARITY_EN, a forced parity flip on a stored word → rsp_perr = 1.

Source files
------------

// File: rtl/frame_table_pkg.sv
// Shared types, constants and helpers for the multi-channel frame descriptor table.
package frame_table_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DefDataWidth = 40;
    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefNCh       = 4;
    localparam int unsigned DefChW       = clog2(DefNCh);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StFlush
    } state_e;

    typedef struct packed {
        logic [DefChW-1:0]       ch;
        logic [DefAddrWidth-1:0] slot;
    } entry_idx_t;

endpackage

// File: rtl/frame_table_sdp.sv
// Simple dual-port RAM: registered read, same-address write-to-read bypass, array not reset.
module frame_table_sdp
    import frame_table_pkg::*;
#(
    parameter int unsigned Width = 40,
    parameter int unsigned Depth = 64,
    localparam int unsigned AddrW = clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_table_mc.sv
// Multi-channel frame descriptor table with valid bits, bypass, invalidate and sweep engine.
// Optional even-parity protection with rsp_perr_o when FRAME_TABLE_PARITY_EN is defined.
module frame_table_mc
    import frame_table_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned N_CH       = DefNCh,
    localparam int unsigned CH_W      = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [CH_W-1:0]       wr_ch_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  inv_valid_i,
    input  logic [CH_W-1:0]       inv_ch_i,
    input  logic [ADDR_WIDTH-1:0] inv_addr_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [CH_W-1:0]       rd_ch_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_hit_o,
`ifdef FRAME_TABLE_PARITY_EN
    output logic                  rsp_perr_o,
`endif
    input  logic                  flush_req_i,
    input  logic [CH_W-1:0]       flush_ch_i,
    output logic                  busy_o
);

    localparam int unsigned IdxW  = CH_W + ADDR_WIDTH;
    localparam int unsigned Depth = 1 << IdxW;
`ifdef FRAME_TABLE_PARITY_EN
    localparam int unsigned RamW  = DATA_WIDTH + 1;
`else
    localparam int unsigned RamW  = DATA_WIDTH;
`endif

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]   fch_q, fch_d;
    logic [Depth-1:0]  valid_q, valid_d;
    logic              rsp_valid_q, rsp_hit_q, hit_d;

    logic              idle, wr_acc, rd_acc, inv_acc;
    logic [IdxW-1:0]   wr_idx, rd_idx, inv_idx, sweep_idx;
    logic              ram_we;
    logic [IdxW-1:0]   ram_waddr;
    logic [RamW-1:0]   wr_word, ram_wdata, ram_rdata;

    assign idle    = (state_q == StIdle);
    assign wr_acc  = wr_valid_i && idle;
    assign rd_acc  = rd_valid_i && idle;
    assign inv_acc = inv_valid_i && idle;
    assign wr_idx  = {wr_ch_i, wr_addr_i};
    assign rd_idx  = {rd_ch_i, rd_addr_i};
    assign inv_idx = {inv_ch_i, inv_addr_i};

    // INIT walks the whole flat index; FLUSH walks only the slots of the latched channel.
    assign sweep_idx = (state_q == StFlush) ? {fch_q, cnt_q[ADDR_WIDTH-1:0]} : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fch_d   = fch_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == '1) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (flush_req_i) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                    fch_d   = flush_ch_i;
                end
            end
            StFlush: begin
                if (cnt_q[ADDR_WIDTH-1:0] == '1) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (state_q == StFlush) begin
            valid_d[sweep_idx] = 1'b0;
        end else begin
            // Write is applied after invalidate so it wins on a same-entry collision.
            if (inv_acc) valid_d[inv_idx] = 1'b0;
            if (wr_acc)  valid_d[wr_idx]  = 1'b1;
        end
    end

    always_comb begin
        if (wr_acc && (wr_idx == rd_idx)) begin
            hit_d = 1'b1;
        end else if (inv_acc && (inv_idx == rd_idx)) begin
            hit_d = 1'b0;
        end else begin
            hit_d = valid_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            fch_q       <= '0;
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fch_q       <= fch_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rd_acc;
            if (rd_acc) begin
                rsp_hit_q <= hit_d;
            end
        end
    end

`ifdef FRAME_TABLE_PARITY_EN
    assign wr_word = {^wr_data_i, wr_data_i};
`else
    assign wr_word = wr_data_i;
`endif

    // Sweep owns the write port whenever it runs; user writes are only accepted in IDLE.
    assign ram_we    = !idle || wr_acc;
    assign ram_waddr = idle ? wr_idx : sweep_idx;
    assign ram_wdata = idle ? wr_word : '0;

    frame_table_sdp #(
        .Width (RamW),
        .Depth (Depth)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    assign wr_ready_o  = idle;
    assign rd_ready_o  = idle;
    assign busy_o      = !idle;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_data_o  = ram_rdata[DATA_WIDTH-1:0];
`ifdef FRAME_TABLE_PARITY_EN
    assign rsp_perr_o  = rsp_valid_q && (^ram_rdata);
`endif

endmodule

// File: tb/tb_frame_table_mc.sv
// Randomized self-checking bench for frame_table_mc against an array-based reference model.
module tb_frame_table_mc;

    localparam int unsigned DW    = 40;
    localparam int unsigned AW    = 4;
    localparam int unsigned NCH   = 4;
    localparam int unsigned SLOTS = 1 << AW;
    localparam int unsigned ENT   = NCH * SLOTS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0, inv_valid = 1'b0, rd_valid = 1'b0, flush_req = 1'b0;
    logic [1:0]    wr_ch = '0, inv_ch = '0, rd_ch = '0, flush_ch = '0;
    logic [AW-1:0] wr_addr = '0, inv_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, rd_ready, rsp_valid, rsp_hit, busy;
    logic [DW-1:0] rsp_data;
`ifdef FRAME_TABLE_PARITY_EN
    logic          rsp_perr;
    bit            m_perr [ENT];
`endif

    logic [DW-1:0] m_data  [ENT];
    bit            m_valid [ENT];
    int            m_busy;
    int            n_checks = 0;
    int            n_errors = 0;

    frame_table_mc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_ch_i     (wr_ch),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .inv_valid_i (inv_valid),
        .inv_ch_i    (inv_ch),
        .inv_addr_i  (inv_addr),
        .rd_valid_i  (rd_valid),
        .rd_ready_o  (rd_ready),
        .rd_ch_i     (rd_ch),
        .rd_addr_i   (rd_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_hit_o   (rsp_hit),
`ifdef FRAME_TABLE_PARITY_EN
        .rsp_perr_o  (rsp_perr),
`endif
        .flush_req_i (flush_req),
        .flush_ch_i  (flush_ch),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
`ifdef FRAME_TABLE_PARITY_EN
            m_perr[i]  = 1'b0;
`endif
        end
        m_busy = ENT;
    endtask

    task automatic quiet();
        wr_valid  = 1'b0;
        inv_valid = 1'b0;
        rd_valid  = 1'b0;
        flush_req = 1'b0;
    endtask

    // One clock: check handshake outputs, apply model rules at the edge, check the response.
    task automatic step();
        bit            idle, exp_rv, exp_h;
        int            widx, ridx, iidx;
        logic [DW-1:0] exp_d;
`ifdef FRAME_TABLE_PARITY_EN
        bit            exp_pe;
`endif
        idle = (m_busy == 0);
        @(negedge clk);
        check_eq("busy", 64'(busy), 64'(!idle));
        check_eq("wr_ready", 64'(wr_ready), 64'(idle));
        check_eq("rd_ready", 64'(rd_ready), 64'(idle));
        widx   = int'(wr_ch) * SLOTS + int'(wr_addr);
        ridx   = int'(rd_ch) * SLOTS + int'(rd_addr);
        iidx   = int'(inv_ch) * SLOTS + int'(inv_addr);
        exp_rv = idle && rd_valid;
        if (wr_valid && widx == ridx) begin
            exp_d = wr_data;
            exp_h = 1'b1;
        end else begin
            exp_d = m_data[ridx];
            exp_h = m_valid[ridx] && !(inv_valid && iidx == ridx);
        end
`ifdef FRAME_TABLE_PARITY_EN
        exp_pe = (wr_valid && widx == ridx) ? 1'b0 : m_perr[ridx];
`endif
        @(posedge clk);
        if (idle) begin
            if (inv_valid) m_valid[iidx] = 1'b0;
            if (wr_valid) begin
                m_data[widx]  = wr_data;
                m_valid[widx] = 1'b1;
`ifdef FRAME_TABLE_PARITY_EN
                m_perr[widx]  = 1'b0;
`endif
            end
            if (flush_req) begin
                for (int s = 0; s < SLOTS; s++) begin
                    m_data[int'(flush_ch) * SLOTS + s]  = '0;
                    m_valid[int'(flush_ch) * SLOTS + s] = 1'b0;
`ifdef FRAME_TABLE_PARITY_EN
                    m_perr[int'(flush_ch) * SLOTS + s]  = 1'b0;
`endif
                end
                m_busy = SLOTS;
            end
        end else begin
            m_busy--;
        end
        #1;
        check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check_eq("rsp_data", 64'(rsp_data), 64'(exp_d));
            check_eq("rsp_hit", 64'(rsp_hit), 64'(exp_h));
`ifdef FRAME_TABLE_PARITY_EN
            check_eq("rsp_perr", 64'(rsp_perr), 64'(exp_pe));
`endif
        end
    endtask

    task automatic do_write(input int ch, input int a, input logic [DW-1:0] d);
        quiet();
        wr_valid = 1'b1; wr_ch = 2'(ch); wr_addr = AW'(a); wr_data = d;
        step();
        quiet();
    endtask

    task automatic do_read(input int ch, input int a);
        quiet();
        rd_valid = 1'b1; rd_ch = 2'(ch); rd_addr = AW'(a);
        step();
        quiet();
    endtask

    task automatic run_idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_checks();
        #1;
        check_eq("rst_busy", 64'(busy), 64'd1);
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd0);
        check_eq("rst_rd_ready", 64'(rd_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_rsp_hit", 64'(rsp_hit), 64'd0);
    endtask

    initial begin
        quiet();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_idle(ENT + 1);

        do_read(2, 5);
        do_write(1, 3, 40'h12_3456_789A);
        do_read(1, 3);

        quiet();
        wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 4'd7; wr_data = 40'hAB;
        rd_valid = 1'b1; rd_ch = 2'd0; rd_addr = 4'd7;
        step();
        quiet();

        for (int s = 0; s < SLOTS; s++) do_write(3, s, {8'($urandom), $urandom});
        for (int s = 0; s < 4; s++) do_write(0, s, {8'($urandom), $urandom});
        quiet();
        flush_req = 1'b1; flush_ch = 2'd3;
        wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 4'd9; wr_data = 40'hC0FFEE;
        step();
        quiet();
        wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 4'd10; wr_data = 40'h55;
        rd_valid = 1'b1; rd_ch = 2'd0; rd_addr = 4'd9;
        for (int i = 0; i < SLOTS; i++) step();
        quiet();
        for (int s = 0; s < SLOTS; s += 5) do_read(3, s);
        for (int s = 0; s < 4; s++) do_read(0, s);
        do_read(0, 9);
        do_read(0, 10);

        quiet();
        wr_valid = 1'b1; wr_ch = 2'd2; wr_addr = 4'd1; wr_data = 40'h77;
        inv_valid = 1'b1; inv_ch = 2'd2; inv_addr = 4'd1;
        step();
        do_read(2, 1);
        quiet();
        inv_valid = 1'b1; inv_ch = 2'd2; inv_addr = 4'd1;
        step();
        do_read(2, 1);
        quiet();
        do_write(2, 2, 40'h99);
        quiet();
        inv_valid = 1'b1; inv_ch = 2'd2; inv_addr = 4'd2;
        rd_valid = 1'b1; rd_ch = 2'd2; rd_addr = 4'd2;
        step();
        quiet();

        for (int i = 0; i < 600; i++) begin
            quiet();
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_ch     = 2'($urandom);
            wr_addr   = AW'($urandom_range(0, 3));
            wr_data   = {8'($urandom), $urandom};
            inv_valid = ($urandom_range(0, 4) == 0);
            inv_ch    = 2'($urandom);
            inv_addr  = AW'($urandom_range(0, 3));
            rd_valid  = ($urandom_range(0, 1) == 0);
            rd_ch     = 2'($urandom);
            rd_addr   = AW'($urandom_range(0, 3));
            flush_req = ($urandom_range(0, 59) == 0);
            flush_ch  = 2'($urandom);
            step();
        end
        quiet();
        run_idle(SLOTS + 1);

`ifdef FRAME_TABLE_PARITY_EN
        do_write(1, 6, 40'h0F_0000_0001);
        dut.u_ram.mem_q[1 * SLOTS + 6][0] = ~dut.u_ram.mem_q[1 * SLOTS + 6][0];
        m_data[1 * SLOTS + 6][0] = ~m_data[1 * SLOTS + 6][0];
        m_perr[1 * SLOTS + 6] = 1'b1;
        do_read(1, 6);
`endif

        do_write(1, 4, 40'h4444);
        quiet();
        flush_req = 1'b1; flush_ch = 2'd1;
        step();
        quiet();
        for (int i = 0; i < 7; i++) step();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_idle(ENT + 1);
        do_read(1, 4);
        do_read(0, 7);
        do_read(3, 0);
        do_read(2, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
